// File: rtl/des_pkg.sv
// ============================================================================
// Module  : des_pkg
// Brief   : DES key-schedule constants (PC1, SHIFT), FSM encoding, helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package des_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  // Per-round left-shift amounts, entry i holds SHIFT[i+1].
  localparam int c_shift [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // PC1 source bit (1 = key MSB) for each of the 56 output bits, output bit 1 first.
  localparam int c_pc1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-c_pc1[i]];
    end
    return r;
  endfunction

  function automatic logic shift_is_two(input logic [3:0] idx);
    return (c_shift[idx] == 2);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_schedule_pc2.sv
// ============================================================================
// Module  : key_schedule_pc2
// Brief   : DES permuted choice 2, 56-bit C||D to 48-bit round subkey.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_schedule_pc2 (
  input  logic [1:56] i_cd,
  output logic [1:48] o_k
);

  localparam int c_pc2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  generate
    for (genvar g = 1; g <= 48; g++) begin : g_pc2
      assign o_k[g] = i_cd[c_pc2[g]];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/key_schedule.sv
// ============================================================================
// Module  : key_schedule
// Brief   : Sequential DES key schedule emitting 16 subkeys with valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_schedule
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        ready,
  output logic [1:48] subkey,
  output logic [3:0]  round,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_mode;
  logic        r_done;
  logic        r_key_err;

  logic [63:0] w_key;
  logic [55:0] w_pc1;
  logic        w_bad;
  logic        w_idle_start;
  logic        w_two;

  assign w_key        = key;
  assign w_pc1        = pc1(w_key);
  assign w_idle_start = (r_state == ST_IDLE) && start;

  generate
    if (PARITY_CHECK != 0) begin : g_parity
      always_comb begin
        w_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
          if (!(^w_key[8*b +: 8])) w_bad = 1'b1;
        end
      end
    end else begin : g_no_parity
      assign w_bad = 1'b0;
    end
  endgenerate

  // Decrypt walks backwards through the table; 4-bit wrap at the end is harmless.
  assign w_two = r_mode ? shift_is_two(4'd15 - r_cnt) : shift_is_two(r_cnt + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_c       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_key_err <= w_idle_start && w_bad;
      case (r_state)
        ST_IDLE: begin
          if (w_idle_start && !w_bad) begin
            // Decrypt starts from C16/D16, which equals the unrotated PC1 value.
            r_c     <= decrypt ? w_pc1[55:28] : rotl28(w_pc1[55:28], 1'b0);
            r_d     <= decrypt ? w_pc1[27:0]  : rotl28(w_pc1[27:0], 1'b0);
            r_mode  <= decrypt;
            r_cnt   <= '0;
            r_state <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (ready) begin
            r_cnt <= r_cnt + 4'd1;
            r_c   <= r_mode ? rotr28(r_c, w_two) : rotl28(r_c, w_two);
            r_d   <= r_mode ? rotr28(r_d, w_two) : rotl28(r_d, w_two);
            if (r_cnt == 4'd15) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  key_schedule_pc2 u_pc2 (
    .i_cd ({r_c, r_d}),
    .o_k  (subkey)
  );

  assign round   = r_mode ? (4'd15 - r_cnt) : r_cnt;
  assign valid   = (r_state == ST_GEN);
  assign busy    = (r_state == ST_GEN);
  assign done    = r_done;
  assign key_err = r_key_err;

endmodule

`default_nettype wire

// File: tb/tb_key_schedule.sv
// ============================================================================
// Module  : tb_key_schedule
// Brief   : Directed self-checking bench for key_schedule (both parity modes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_schedule;

  typedef struct {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } vec_t;

  localparam logic [63:0] c_key_std  = 64'h133457799BBCDFF1;
  localparam logic [63:0] c_key_zero = 64'h0000000000000000;
  localparam logic [63:0] c_key_w0   = 64'h0101010101010101;
  localparam logic [63:0] c_key_w1   = 64'hFEFEFEFEFEFEFEFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic [1:64] key = '0;
  logic decrypt = 1'b0;
  logic ready = 1'b1;
  logic sel = 1'b0;

  logic [1:48] sk0, sk1;
  logic [3:0]  rnd0, rnd1;
  logic        valid0, valid1, busy0, busy1, done0, done1, kerr0, kerr1;

  logic [47:0] m_sk;
  logic [3:0]  m_rnd;
  logic        m_valid, m_busy, m_done;

  int checks = 0;
  int failures = 0;
  logic kerr0_seen = 1'b0;
  logic [47:0] c_kv [0:15];
  vec_t tab [0:15];

  always #5 clk = ~clk;

  key_schedule #(.PARITY_CHECK(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .key(key), .decrypt(decrypt), .ready(ready),
    .subkey(sk0), .round(rnd0), .valid(valid0), .busy(busy0), .done(done0), .key_err(kerr0)
  );

  key_schedule #(.PARITY_CHECK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .key(key), .decrypt(decrypt), .ready(ready),
    .subkey(sk1), .round(rnd1), .valid(valid1), .busy(busy1), .done(done1), .key_err(kerr1)
  );

  assign m_sk    = sel ? sk1 : sk0;
  assign m_rnd   = sel ? rnd1 : rnd0;
  assign m_valid = sel ? valid1 : valid0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;

  always @(posedge clk) if (kerr0) kerr0_seen <= 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] exp_sk(input int tsel, input int idx);
    if (tsel == 0) return tab[idx].sk;
    if (tsel == 1) return 48'h0;
    return {48{1'b1}};
  endfunction

  // Full schedule on one DUT, optionally with random back-pressure.
  task automatic run_sched(input logic dut, input logic dec, input logic [63:0] k,
                           input int tsel, input logic rnd_ready, input string tag);
    int pos;
    int cyc;
    int idx;
    pos = 0;
    cyc = 0;
    sel = dut;
    key = k;
    decrypt = dec;
    ready = 1'b1;
    if (dut) start1 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    while (pos < 16 && cyc < 400) begin
      idx = dec ? 15 - pos : pos;
      chk({tag, "_valid"}, 64'(m_valid), 64'd1);
      chk({tag, "_busy"}, 64'(m_busy), 64'd1);
      chk({tag, "_subkey"}, 64'(m_sk), 64'(exp_sk(tsel, idx)));
      chk({tag, "_round"}, 64'(m_rnd), 64'(tab[idx].rnd));
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (ready) pos++;
      cyc++;
    end
    chk({tag, "_handshakes"}, 64'(pos), 64'd16);
    chk({tag, "_done"}, 64'(m_done), 64'd1);
    chk({tag, "_valid_after"}, 64'(m_valid), 64'd0);
    chk({tag, "_busy_after"}, 64'(m_busy), 64'd0);
    ready = 1'b1;
    step();
    chk({tag, "_done_pulse"}, 64'(m_done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic saw_done;

    c_kv = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    for (int i = 0; i < 16; i++) begin
      tab[i].rnd = 4'(i);
      tab[i].sk  = c_kv[i];
    end

    repeat (3) step();
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_key_err", 64'(kerr1), 64'd0);
    chk("rst_subkey", 64'(sk0), 64'd0);
    chk("rst_round", 64'(rnd0), 64'd0);
    rst = 1'b0;
    step();

    run_sched(1'b0, 1'b0, c_key_std, 0, 1'b0, "enc");
    run_sched(1'b0, 1'b1, c_key_std, 0, 1'b0, "dec");
    run_sched(1'b0, 1'b0, c_key_std, 0, 1'b1, "enc_stall");
    run_sched(1'b0, 1'b1, c_key_std, 0, 1'b1, "dec_stall");

    // Bad parity is rejected by the checking instance only.
    sel = 1'b1;
    key = c_key_zero;
    decrypt = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("par_key_err", 64'(kerr1), 64'd1);
    chk("par_valid", 64'(valid1), 64'd0);
    chk("par_busy", 64'(busy1), 64'd0);
    step();
    chk("par_key_err_pulse", 64'(kerr1), 64'd0);
    chk("par_valid_later", 64'(valid1), 64'd0);
    run_sched(1'b0, 1'b0, c_key_zero, 1, 1'b0, "nopar_zero");
    run_sched(1'b1, 1'b0, c_key_w0, 1, 1'b0, "par_w0");
    run_sched(1'b1, 1'b1, c_key_w1, 2, 1'b1, "par_w1_dec");

    // Reset in the middle of a schedule.
    sel = 1'b0;
    key = c_key_std;
    decrypt = 1'b0;
    ready = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_round7", 64'(rnd0), 64'd7);
    chk("mid_subkey7", 64'(sk0), 64'(tab[7].sk));
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", 64'(valid0), 64'd0);
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_subkey", 64'(sk0), 64'd0);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done0 || valid0) saw_done = 1'b1;
      step();
    end
    chk("mid_no_done", 64'(saw_done), 64'd0);
    run_sched(1'b0, 1'b0, c_key_std, 0, 1'b0, "restart");

    // start held high: ignored while busy, re-accepted in the done cycle.
    sel = 1'b0;
    key = c_key_std;
    decrypt = 1'b0;
    ready = 1'b1;
    start0 = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("hold_subkey", 64'(sk0), 64'(tab[i].sk));
      chk("hold_round", 64'(rnd0), 64'(i));
      step();
    end
    chk("hold_done", 64'(done0), 64'd1);
    chk("hold_idle", 64'(busy0), 64'd0);
    step();
    start0 = 1'b0;
    chk("hold_reaccept_valid", 64'(valid0), 64'd1);
    chk("hold_reaccept_round", 64'(rnd0), 64'd0);
    chk("hold_reaccept_subkey", 64'(sk0), 64'(tab[0].sk));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    chk("nopar_key_err_never", 64'(kerr0_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have parameter PARITY_CHECK, default 0, meaning: 1 = reject keys whose bytes are not all odd parity.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  request to begin a 16-subkey schedule.
REQ-005 SHALL have port key  in  [1:64]  DES key, bit 1 = MSB; bits 8,16,...,64 are parity bits.
REQ-006 SHALL have port decrypt  in  1  0 = emit K1..K16; 1 = emit K16..K1.
REQ-007 SHALL have port ready  in  1  downstream accepts the current subkey.
REQ-008 SHALL have port subkey  out  [1:48]  current round subkey, bit 1 = MSB.
REQ-009 SHALL have port round  out  4  index of the emitted subkey, 1..16 encoded 0..15.
REQ-010 SHALL have port valid  out  1  subkey and round are valid.
REQ-011 SHALL have port busy  out  1  a schedule is in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last handshake.
REQ-013 SHALL have port key_err  out  1  one-cycle pulse on a rejected key.

Function
REQ-014 SHALL implement FSM states IDLE and GEN.
REQ-015 In IDLE, start=1 SHALL be accepted; in GEN, start SHALL be ignored.
REQ-016 On accept, C/D registers (28 b each) SHALL load PC1(key), rotated left by 1 in encrypt mode and unrotated in decrypt mode; mode SHALL be latched.
REQ-017 On accept, the FSM SHALL enter GEN and set the round counter to 0.
REQ-018 subkey SHALL equal PC2(C||D) taken from the registers, with no combinational path from key.
REQ-019 valid SHALL equal (state==GEN), so the first valid is one cycle after accept.
REQ-020 A handshake occurs when valid&ready; on each handshake, the round counter SHALL increment and C/D SHALL rotate for the next subkey.
REQ-021 Encrypt rotation SHALL be left by SHIFT[r+1] when leaving round r.
REQ-022 Decrypt rotation SHALL be right by SHIFT[17-r] when leaving output position r.
REQ-023 SHIFT[1..16] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-024 While valid&!ready, subkey, round and C/D SHALL hold stable.
REQ-025 round SHALL report the true subkey index (encrypt: position; decrypt: 17-position), encoded minus 1.
REQ-026 The handshake on the 16th subkey SHALL return the FSM to IDLE and drive done=1 for exactly the next cycle.
REQ-027 With ready held at 1, 16 subkeys SHALL be emitted on 16 consecutive cycles.
REQ-028 busy SHALL equal (state==GEN).
REQ-029 start asserted in the same cycle as done SHALL be accepted.
REQ-030 If PARITY_CHECK=1 and any key byte has even parity, start SHALL NOT be accepted: key_err=1 for one cycle, state stays IDLE.
REQ-031 If PARITY_CHECK=0, parity bits SHALL be ignored and key_err SHALL be constant 0.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, C=D=0, round counter=0, mode=0.
REQ-033 rst=1 SHALL immediately force valid=busy=done=key_err=0; subkey then reads PC2(0)=0.
REQ-034 Reset mid-schedule SHALL abandon the schedule with no done pulse; the first post-reset start SHALL behave as from power-up.

Structure
REQ-035 Package des_pkg SHALL hold the SHIFT table, FSM state encoding, and the PC1 mapping as a constant/function.
REQ-036 The existing 56->48 permutation PC2 SHALL be instantiated once as the only sub-module; PC1 and rotations SHALL stay inline.

Verification
REQ-037 Encrypt, key=133457799BBCDFF1, ready=1 -> K1=1B02EFFC7072 one cycle after start, round=0; K16=CB3D8B0E17F5 at round=15; done one cycle later.
REQ-038 Decrypt, same key -> first subkey CB3D8B0E17F5 with round=15; last subkey 1B02EFFC7072 with round=0.
REQ-039 Encrypt with ready toggled randomly -> identical 16-key sequence, outputs stable during every stall, exactly 16 handshakes.
REQ-040 PARITY_CHECK=1, key=0000000000000000 -> key_err pulse, valid stays 0; PARITY_CHECK=0 with the same key -> normal schedule.
REQ-041 rst asserted at round 7 -> valid/busy drop asynchronously, no done; a restart then reproduces the REQ-037 sequence.
REQ-042 start held high through a schedule -> no re-accept while busy; new schedule accepted in the done cycle.
